// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: request bus between two requesters and the SRAM access controller.
// Ports (signals):
//   req_valid [1:0]         per-requester command valid (bit i = requester i)
//   req_ready [1:0]         per-requester accept strobe (combinational, from controller)
//   req_op    [3:0]         packed 2-bit opcode per requester: 00 READ1, 01 READ2, 10 WRITE, 11 COMPUTE
//   req_src1/src2/dst       packed ADDR_W-bit rows per requester (requester i in slice i)
// Modports: master drives commands, slave (the controller) drives req_ready.
interface sram_access_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [3:0]          req_op;
  logic [2*ADDR_W-1:0] req_src1;
  logic [2*ADDR_W-1:0] req_src2;
  logic [2*ADDR_W-1:0] req_dst;

  modport master (
    output req_valid, req_op, req_src1, req_src2, req_dst,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, req_dst,
    output req_ready
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: arbitrates two requesters round-robin and sequences one SRAM
// operation at a time (read one/two rows, write a row, or read-then-write compute).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req                        request bus (slave modport)
//   read_address1/2, read_enable1/2   decoder read ports (address 0 when disabled)
//   write_address, write_enable       decoder write port (address 0 when disabled)
//   done_valid, done_id        one-cycle completion pulse and requester index
//   busy                       high whenever the controller is not idle
module sram_access_ctrl #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_access_ctrl_if.slave   req,
  output logic [ADDR_W-1:0]   read_address1,
  output logic [ADDR_W-1:0]   read_address2,
  output logic                read_enable1,
  output logic                read_enable2,
  output logic [ADDR_W-1:0]   write_address,
  output logic                write_enable,
  output logic                done_valid,
  output logic                done_id,
  output logic                busy
);
  localparam int unsigned CNT_W = 3;
  localparam logic [1:0] OP_READ2   = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_COMPUTE = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WB, DONE} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dst;
    logic              id;
  } cmd_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  cmd_t             cmd, cmd_nxt, sel_cmd;
  logic             last_grant, last_grant_nxt;
  logic             grant_c, accept_c;

  logic [ADDR_W-1:0] ra1_nxt, ra2_nxt, wa_nxt;
  logic              re1_nxt, re2_nxt, we_nxt, dv_nxt, did_nxt, busy_nxt;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    if (req.req_valid == 2'b11) grant_c = ~last_grant;
    else                        grant_c = req.req_valid[1];
  end

  assign req.req_ready = (state == IDLE) ? (req.req_valid & (grant_c ? 2'b10 : 2'b01)) : 2'b00;
  assign accept_c      = |req.req_ready;

  // Unpack the granted requester's command slice.
  always_comb begin
    sel_cmd.id = grant_c;
    if (grant_c) begin
      sel_cmd.op   = req.req_op[3:2];
      sel_cmd.src1 = req.req_src1[2*ADDR_W-1:ADDR_W];
      sel_cmd.src2 = req.req_src2[2*ADDR_W-1:ADDR_W];
      sel_cmd.dst  = req.req_dst[2*ADDR_W-1:ADDR_W];
    end else begin
      sel_cmd.op   = req.req_op[1:0];
      sel_cmd.src1 = req.req_src1[ADDR_W-1:0];
      sel_cmd.src2 = req.req_src2[ADDR_W-1:0];
      sel_cmd.dst  = req.req_dst[ADDR_W-1:0];
    end
  end

  // Next state plus next values of the registered outputs, decoded from the next state.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cmd_nxt        = cmd;
    last_grant_nxt = last_grant;

    case (state)
      IDLE: begin
        if (accept_c) begin
          cmd_nxt        = sel_cmd;
          last_grant_nxt = grant_c;
          state_nxt      = (sel_cmd.op == OP_WRITE) ? WB : RD;
        end
      end
      RD: begin
        cnt_nxt   = CNT_W'(READ_LAT - 1);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = (cmd.op == OP_COMPUTE) ? WB : DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      WB:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    re1_nxt  = (state_nxt == RD);
    re2_nxt  = re1_nxt && ((cmd_nxt.op == OP_READ2) || (cmd_nxt.op == OP_COMPUTE));
    we_nxt   = (state_nxt == WB);
    dv_nxt   = (state_nxt == DONE);
    ra1_nxt  = re1_nxt ? cmd_nxt.src1 : '0;
    ra2_nxt  = re2_nxt ? cmd_nxt.src2 : '0;
    wa_nxt   = we_nxt  ? cmd_nxt.dst  : '0;
    did_nxt  = dv_nxt  ? cmd_nxt.id   : 1'b0;
    busy_nxt = (state_nxt != IDLE);
  end

  // State, captured command and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cmd           <= '0;
      last_grant    <= 1'b1;
      read_address1 <= '0;
      read_address2 <= '0;
      read_enable1  <= 1'b0;
      read_enable2  <= 1'b0;
      write_address <= '0;
      write_enable  <= 1'b0;
      done_valid    <= 1'b0;
      done_id       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      cmd           <= cmd_nxt;
      last_grant    <= last_grant_nxt;
      read_address1 <= ra1_nxt;
      read_address2 <= ra2_nxt;
      read_enable1  <= re1_nxt;
      read_enable2  <= re2_nxt;
      write_address <= wa_nxt;
      write_enable  <= we_nxt;
      done_valid    <= dv_nxt;
      done_id       <= did_nxt;
      busy          <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed, table-driven bench for sram_access_ctrl
// (READ_LAT=1 instance) plus a READ_LAT=3 instance for latency checks.
module tb_sram_access_ctrl;
  localparam int unsigned AW = 7;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_access_ctrl_if #(.ADDR_W(AW)) bus ();
  sram_access_ctrl_if #(.ADDR_W(AW)) bus3 ();

  logic [AW-1:0] ra1, ra2, wa, ra1_3, ra2_3, wa_3;
  logic re1, re2, we, dv, did, busy;
  logic re1_3, re2_3, we_3, dv_3, did_3, busy_3;

  sram_access_ctrl #(.ADDR_W(AW), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus),
    .read_address1(ra1), .read_address2(ra2),
    .read_enable1(re1), .read_enable2(re2),
    .write_address(wa), .write_enable(we),
    .done_valid(dv), .done_id(did), .busy(busy)
  );

  sram_access_ctrl #(.ADDR_W(AW), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(bus3),
    .read_address1(ra1_3), .read_address2(ra2_3),
    .read_enable1(re1_3), .read_enable2(re2_3),
    .write_address(wa_3), .write_enable(we_3),
    .done_valid(dv_3), .done_id(did_3), .busy(busy_3)
  );

  typedef struct packed {
    logic          re1;
    logic [AW-1:0] ra1;
    logic          re2;
    logic [AW-1:0] ra2;
    logic          we;
    logic [AW-1:0] wa;
    logic          dv;
    logic          did;
    logic          busy;
  } obs_t;

  // Cycle numbers count from the accept edge; 0 means "never".
  typedef struct {
    int            id;
    logic [1:0]    op;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] d;
    int            rd_c;
    logic          two;
    int            wb_c;
    int            done_c;
  } vec_t;

  function automatic obs_t obs1();
    return obs_t'({re1, ra1, re2, ra2, we, wa, dv, dv ? did : 1'b0, busy});
  endfunction

  function automatic obs_t obs3();
    return obs_t'({re1_3, ra1_3, re2_3, ra2_3, we_3, wa_3, dv_3, dv_3 ? did_3 : 1'b0, busy_3});
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input int id, input logic [1:0] op, input logic [AW-1:0] s1,
                       input logic [AW-1:0] s2, input logic [AW-1:0] d);
    bus.req_valid[id] = 1'b1;
    if (id == 0) begin
      bus.req_op[1:0] = op; bus.req_src1[AW-1:0] = s1;
      bus.req_src2[AW-1:0] = s2; bus.req_dst[AW-1:0] = d;
    end else begin
      bus.req_op[3:2] = op; bus.req_src1[2*AW-1:AW] = s1;
      bus.req_src2[2*AW-1:AW] = s2; bus.req_dst[2*AW-1:AW] = d;
    end
  endtask

  task automatic wait_ready(input logic [1:0] mask, input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((bus.req_ready & mask) != 2'b00) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: ready timeout got=%b exp_any_of=%b", name, bus.req_ready, mask);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    obs_t e;
    int   last_acc;
    int   seen;
    logic ok3;

    total = 0; bad = 0; cyc = 0;
    vt[0] = '{0, 2'b01, 7'd5,   7'd9,  7'd0,   1, 1'b1, 0, 3};  // READ2
    vt[1] = '{1, 2'b11, 7'd3,   7'd4,  7'd3,   1, 1'b1, 3, 4};  // COMPUTE dst==src1
    vt[2] = '{0, 2'b10, 7'd11,  7'd12, 7'd127, 0, 1'b0, 1, 2};  // WRITE top row
    vt[3] = '{1, 2'b00, 7'd127, 7'd66, 7'd1,   1, 1'b0, 0, 3};  // READ1
    vt[4] = '{0, 2'b11, 7'd10,  7'd20, 7'd20,  1, 1'b1, 3, 4};  // COMPUTE dst==src2

    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_src1 = '0; bus.req_src2 = '0; bus.req_dst = '0;
    bus3.req_valid = '0; bus3.req_op = '0; bus3.req_src1 = '0; bus3.req_src2 = '0; bus3.req_dst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(obs1()), 32'd0);
    check("reset_outputs_l3", 32'(obs3()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single-operation vectors with cycle-by-cycle output expectations.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(vt[i].id, vt[i].op, vt[i].s1, vt[i].s2, vt[i].d);
      wait_ready(vt[i].id == 0 ? 2'b01 : 2'b10, $sformatf("vec%0d_ready", i));
      @(posedge clk); #1;
      bus.req_valid = '0;
      bus.req_src1 = '1; bus.req_src2 = '1; bus.req_dst = '0; bus.req_op = '1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        e      = '0;
        e.re1  = (k == vt[i].rd_c);
        e.ra1  = e.re1 ? vt[i].s1 : '0;
        e.re2  = e.re1 && vt[i].two;
        e.ra2  = e.re2 ? vt[i].s2 : '0;
        e.we   = (k == vt[i].wb_c);
        e.wa   = e.we ? vt[i].d : '0;
        e.dv   = (k == vt[i].done_c);
        e.did  = e.dv ? 1'(vt[i].id) : 1'b0;
        e.busy = (k <= vt[i].done_c);
        check($sformatf("vec%0d_cyc%0d", i, k), 32'(obs1()), 32'(e));
      end
    end

    // Round-robin with both requesters holding WRITE commands after reset.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 2'b10, 7'd0, 7'd0, 7'd21);
    drive(1, 2'b10, 7'd0, 7'd0, 7'd42);
    last_acc = 0;
    for (int n = 0; n < 4; n++) begin
      wait_ready(2'b11, $sformatf("rr%0d_ready", n));
      check($sformatf("rr%0d_grant", n), 32'(bus.req_ready), (n % 2 == 0) ? 32'd1 : 32'd2);
      if (n > 0) check($sformatf("rr%0d_gap", n), 32'(cyc - last_acc), 32'd3);
      last_acc = cyc;
      @(posedge clk); #1;
      if (n == 3) bus.req_valid = '0;
      @(negedge clk);
      check($sformatf("rr%0d_c1", n), {bus.req_ready, we, wa, dv},
            {2'b00, 1'b1, (n % 2 == 0) ? 7'd21 : 7'd42, 1'b0});
      @(negedge clk);
      check($sformatf("rr%0d_c2", n), {bus.req_ready, we, dv, did},
            {2'b00, 1'b0, 1'b1, 1'(n % 2)});
    end

    // COMPUTE aborted by reset while in WAIT.
    @(posedge clk); #1;
    drive(1, 2'b11, 7'd8, 7'd9, 7'd8);
    wait_ready(2'b10, "abort_ready");
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    check("abort_rd", {re1, re2, ra1, ra2}, {1'b1, 1'b1, 7'd8, 7'd9});
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_wait", {busy, re1, we, dv}, 4'b1000);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'(obs1()), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (we || dv || busy) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // READ_LAT=3 instance: READ1 of row 0.
    @(posedge clk); #1;
    bus3.req_valid = 2'b01; bus3.req_op = 4'b0000;
    bus3.req_src1 = '0; bus3.req_src2 = 14'd5; bus3.req_dst = 14'd7;
    ok3 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus3.req_ready == 2'b01) begin ok3 = 1'b1; break; end
    end
    check("l3_ready", 32'(ok3), 32'd1);
    @(posedge clk); #1 bus3.req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e      = '0;
      e.re1  = (k == 1);
      e.dv   = (k == 5);
      e.busy = (k <= 5);
      check($sformatf("l3_cyc%0d", k), 32'(obs3()), 32'(e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7: wordline address width, matching the 128-row decoder.
REQ-002 Parameter READ_LAT, default 1, legal 1..7: cycles from read-enable deassertion until read data is valid.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester command valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept strobe.
REQ-007 req_op  input  4  packed 2-bit opcode per requester: 00 READ1, 01 READ2, 10 WRITE, 11 COMPUTE.
REQ-008 req_src1  input  2*ADDR_W  packed first source row per requester.
REQ-009 req_src2  input  2*ADDR_W  packed second source row per requester.
REQ-010 req_dst  input  2*ADDR_W  packed destination row per requester.
REQ-011 read_address1 / read_address2  output  ADDR_W each  decoder read-port rows.
REQ-012 read_enable1 / read_enable2  output  1 each  decoder read-port enables.
REQ-013 write_address  output  ADDR_W  decoder write row.
REQ-014 write_enable  output  1  decoder write enable.
REQ-015 done_valid  output  1  one-cycle completion pulse.
REQ-016 done_id  output  1  index of the requester whose operation completed; valid only with done_valid.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, RD, WAIT, WB, DONE; all outputs registered.
REQ-019 Acceptance: req_ready[i] asserts combinationally only in IDLE, only when req_valid[i] is high and requester i holds the grant; at most one req_ready bit is high per cycle.
REQ-020 Arbitration is round-robin:
- when both requesters are valid, grant goes to the requester not granted last;
- when one is valid, it is granted;
- the last-grant register updates on acceptance only.
REQ-021 On acceptance, opcode, src1, src2, dst and requester index are captured; later input changes have no effect on the in-flight operation.
REQ-022 Transitions from IDLE on acceptance: READ1, READ2 and COMPUTE go to RD; WRITE goes to WB.
REQ-023 RD lasts exactly one cycle, driving read_address1=src1 with read_enable1=1.
- READ2 and COMPUTE additionally drive read_address2=src2 with read_enable2=1.
- Next state is WAIT.
REQ-024 WAIT lasts exactly READ_LAT cycles, counted by a 3-bit down-counter; all enables are 0. Exit goes to WB for COMPUTE and to DONE otherwise.
REQ-025 WB lasts exactly one cycle, driving write_address=dst with write_enable=1; next state is DONE.
REQ-026 DONE lasts one cycle with done_valid=1 and done_id=captured index; next state is IDLE.
REQ-027 Latencies with READ_LAT=1, counting from the accept edge:
- READ1/READ2: done_valid in cycle 3;
- COMPUTE: done_valid in cycle 4;
- WRITE: done_valid in cycle 2;
- the next acceptance can occur in the cycle after DONE.
REQ-028 write_enable and either read_enable are never high in the same cycle.
REQ-029 Every address output is 0 whenever its enable is 0.
REQ-030 COMPUTE with dst equal to src1 or src2 is legal: reads complete before the write by construction.
REQ-031 No operation is accepted while busy; requesters hold req_valid until ready.

Reset
REQ-032 While rst_n=0 at a clock edge:
- state returns to IDLE;
- all enables, addresses, done_valid, done_id and busy are cleared to 0;
- the WAIT counter clears to 0;
- the last-grant register is set to 1, so requester 0 wins the first contention.
REQ-033 A reset during RD, WAIT or WB aborts the operation: no further enable and no done_valid for it.

Verification
REQ-034 Req0 READ2, src1=5, src2=9 -> cycle1: read_enable1/2=1, read_address1=5, read_address2=9; cycle3: done_valid=1, done_id=0.
REQ-035 Req1 COMPUTE, src1=3, src2=4, dst=3 -> cycle1: reads at rows 3 and 4; cycle3: write_enable=1, write_address=3; cycle4: done_valid=1, done_id=1; read and write enables never overlap.
REQ-036 Both requesters hold valid continuously with WRITE ops after reset -> grants alternate 0,1,0,1; each done pulse follows 2 cycles after its accept.
REQ-037 Req0 WRITE, dst=127 -> cycle1: write_enable=1, write_address=127; cycle2: done_valid=1; cycle3: req_ready[0] can reassert.
REQ-038 COMPUTE accepted, rst_n=0 during WAIT -> next cycle: IDLE, busy=0; no write_enable and no done_valid ever occur for that operation.
REQ-039 READ_LAT=3 build, READ1 src1=0 -> enable in cycle1, WAIT in cycles 2-4, done_valid in cycle5.
